riscv_fetch_unit: RTL
=====================

# riscv_fetch_unit

Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the zero-latency instruction-memory lookup of the single-cycle processor. It owns the program counter and issues word fetches over a req/ack handshake that tolerates any memory latency. Fetched words are buffered in a DEPTH-entry prefetch queue, and the queue and any in-flight fetch are squashed on a branch/jump redirect from the execute stage.

## Interface
- XLEN, 32: address/PC width; supported values are 32 and 64.
- DEPTH, 4: prefetch queue entries, ≥2, power of two.
- RESET_PC, 0: fetch address after reset; bits [1:0] must be 0.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_req  out  1  fetch request.
- mem_addr  out  XLEN  fetch address, word aligned.
- mem_ack  in  1  request accepted and mem_rdata valid in this same cycle.
- mem_rdata  in  32  instruction word.
- redirect  in  1  squash and restart fetch.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid  out  1  queue head is valid.
- instr  out  32  queue head instruction.
- instr_pc  out  XLEN  address of the queue head.
- instr_ready  in  1  consumer takes the head this cycle.
- PC  out  XLEN  next address to be fetched.
- occupancy  out  $clog2(DEPTH+1)  entries in the queue.

## Operation
- FSM states: START, FETCH, DISCARD. All three reset to START.
- START: mem_req=0. Moves unconditionally to FETCH on the next edge, unless redirect is asserted; in that case PC is loaded and the FSM still moves to FETCH.
- FETCH: mem_req = (occupancy < DEPTH), mem_addr = PC.
  - Handshake fires on mem_req && mem_ack.
  - On a fire, {PC, mem_rdata} is pushed into the queue and PC advances by 4, wrapping modulo 2^XLEN.
- Once mem_req rises, it and mem_addr stay stable until mem_ack. This holds because occupancy cannot rise while a fetch is pending.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle leave occupancy unchanged.
- Redirect has priority over push and pop:
  - Queue is flushed, occupancy=0, and PC=redirect_pc & ~3.
  - If mem_req && !mem_ack in the redirect cycle, the FSM goes to DISCARD.
  - Otherwise the FSM stays in FETCH; an acked word in the redirect cycle is dropped.
- DISCARD: mem_req=1 and mem_addr hold the old address until mem_ack. The response is dropped, the FSM returns to FETCH, and PC is not advanced.
  - A further redirect while in DISCARD only updates PC.
- instr_valid = (occupancy != 0). instr and instr_pc come straight from queue registers, with no combinational path from the memory inputs.
- There is no combinational path from instr_ready to mem_req.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, PC=RESET_PC, instr_valid=0, instr=0, instr_pc=0, occupancy=0.
- First request is asserted in the second cycle after reset release: START lasts one cycle.
- Latency: ack in cycle t into an empty queue gives instr_valid=1 in cycle t+1.
- Throughput: one word per cycle when mem_ack is tied high and the consumer is always ready.
- Queue full: mem_req=0 for that cycle. A pop in cycle t raises mem_req in cycle t+1.
- Redirect in cycle t: instr_valid=0 in t+1. A new request to redirect_pc is raised in t+1, or after the discarded ack when in DISCARD.
- Reset asserted mid-operation: all outputs return to reset values at once; any in-flight fetch is abandoned.

## Structure
- Shared package riscv_pkg holds:
  - XLEN default and RESET_PC default;
  - the fetch FSM state enum fetch_state_t {START, FETCH, DISCARD};
  - the queue entry struct {pc, instr}.
- One sub-module: fetch_queue.
  - Parametrised synchronous FIFO: DEPTH, entry type, push/pop/flush, registered head, occupancy.
  - flush overrides push in the same cycle.
- FSM, PC register and handshake logic stay in riscv_fetch_unit.

## Test plan
- Reset release with mem_ack tied 1 and instr_ready tied 1 → requests issued at 0x0, 0x4, 0x8… one per cycle; instr_pc follows one cycle behind.
- Memory latency of 3 cycles, DEPTH=4, instr_ready=0 → exactly 4 acks occur; mem_req then stays 0 and occupancy=4.
  - Then a single-cycle pop → mem_req=1 on the next cycle at address 0x10.
- Redirect to 0x103 while a request to 0x8 is pending → FSM enters DISCARD and mem_addr holds 0x8 until ack.
  - That word never appears on instr.
  - The next request is to 0x100.
- Redirect in the same cycle as an ack and a pop with occupancy=2 → occupancy=0 next cycle, PC=redirect_pc, no stale instr_valid.
- PC=0xFFFFFFFC with XLEN=32 → the next request after the ack is 0x00000000.
- Assert reset asynchronously mid-stall while in DISCARD → mem_req=0 and occupancy=0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch front end.
//   XLEN_DEFAULT     : default address/PC width
//   RESET_PC_DEFAULT : default fetch address after reset (widest XLEN)
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : prefetch queue entry {pc, instr} at the default XLEN
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

    typedef enum logic [1:0] {
        START,
        FETCH,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack channel plus the
// instruction stream handed to decode.
//   master : the fetch unit (drives mem_req/mem_addr and the instr stream)
//   slave  : memory + consumer side (drives mem_ack/mem_rdata/instr_ready)
interface riscv_fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO.
//   clk, reset : clock, async active-high reset
//   push/push_data : write an entry (ignored when flush is high)
//   pop        : remove the head (caller guarantees non-empty)
//   flush      : empty the queue; overrides push and pop
//   head       : current head entry, read straight from the storage registers
//   occupancy  : number of valid entries
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    entry_t        slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] count;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + OW'(push) - OW'(pop);
        end
    end

    assign head      = slots[rd_ptr];
    assign occupancy = count;
endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches over a
// latency-tolerant req/ack handshake, buffers words in a prefetch queue and
// squashes queue + in-flight fetch on a redirect.
//   clk, reset   : clock, async active-high reset
//   bus          : memory req/ack channel and instr stream (master side)
//   redirect     : squash and restart fetch at redirect_pc (bits [1:0] dropped)
//   PC           : next address to be fetched
//   occupancy    : entries in the prefetch queue
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    riscv_fetch_unit_if.master         bus,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic [XLEN-1:0]            PC,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] discard_addr;
    logic            fire;
    logic            pop;
    entry_t          push_data;
    entry_t          head;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            START:   state_next = FETCH;
            FETCH:   if (redirect && bus.mem_req && !bus.mem_ack) state_next = DISCARD;
            DISCARD: if (bus.mem_ack) state_next = FETCH;
            default: state_next = START;
        endcase
    end

    // Outputs: depend only on registered state, never on instr_ready.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_addr = PC;
        unique case (state)
            START:   bus.mem_req = 1'b0;
            FETCH:   bus.mem_req = (occupancy != OW'(DEPTH));
            DISCARD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = discard_addr;
            end
            default: bus.mem_req = 1'b0;
        endcase
    end

    assign fire = (state == FETCH) && bus.mem_req && bus.mem_ack;
    assign pop  = bus.instr_valid && bus.instr_ready;

    // PC is free to follow a redirect while DISCARD keeps the abandoned
    // request's address stable on mem_addr via discard_addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC           <= RESET_PC;
            discard_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                PC <= redirect_pc & ~XLEN'(3);
            end else if (fire) begin
                PC <= PC + XLEN'(4);
            end
            if (state == FETCH && state_next == DISCARD) begin
                discard_addr <= PC;
            end
        end
    end

    assign push_data.pc    = PC;
    assign push_data.instr = bus.mem_rdata;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .occupancy (occupancy)
    );

    assign bus.instr_valid = (occupancy != '0);
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
endmodule
